// File: rtl/hex_seg_reader_pkg.sv
// Shared definitions for the 7-segment capture path: segment patterns,
// decode result kinds and the stability FSM states.
package hex_seg_reader_pkg;

   localparam int unsigned SEG_W  = 7;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned KIND_W = 2;

   // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g.
   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0011000;
   localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
   localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
   localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
   localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
   localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [KIND_W-1:0] {
      KIND_HEX   = 2'd0,
      KIND_BLANK = 2'd1,
      KIND_INV   = 2'd2,
      KIND_RSVD  = 2'd3
   } kind_e;

   typedef enum logic [1:0] {
      ST_SETTLE  = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_HOLD    = 2'd2
   } state_e;

   // Forward mapping, kept beside the inverse so both sides share one table.
   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nib);
      logic [SEG_W-1:0] s;
      case (nib)
         4'h0: s = SEG_0;
         4'h1: s = SEG_1;
         4'h2: s = SEG_2;
         4'h3: s = SEG_3;
         4'h4: s = SEG_4;
         4'h5: s = SEG_5;
         4'h6: s = SEG_6;
         4'h7: s = SEG_7;
         4'h8: s = SEG_8;
         4'h9: s = SEG_9;
         4'hA: s = SEG_A;
         4'hB: s = SEG_B;
         4'hC: s = SEG_C;
         4'hD: s = SEG_D;
         4'hE: s = SEG_E;
         default: s = SEG_F;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/hex_seg_reader_if.sv
// Display bus (segments + anodes) and the recovered-digit event stream.
interface hex_seg_reader_if
   import hex_seg_reader_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned IDX_W  = 2
);
   logic [SEG_W-1:0]  seg;
   logic [DIGITS-1:0] an;
   logic              out_valid;
   logic              out_ready;
   logic [IDX_W-1:0]  out_idx;
   logic [NIB_W-1:0]  out_nib;
   logic [KIND_W-1:0] out_kind;

   // Reader side: watches the display, produces events.
   modport master (
      input  seg, an, out_ready,
      output out_valid, out_idx, out_nib, out_kind
   );

   // Display driver / event consumer side.
   modport slave (
      output seg, an, out_ready,
      input  out_valid, out_idx, out_nib, out_kind
   );
endinterface

// File: rtl/hex_seg_inv.sv
// Inverse 7-segment decode: segment pattern to nibble plus pattern kind.
module hex_seg_inv
   import hex_seg_reader_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output logic [NIB_W-1:0] nib,
   output kind_e            kind
);

   // Table lookup; nibble forced to 0 for anything that is not a hex glyph.
   always_comb begin
      nib  = '0;
      kind = KIND_HEX;
      case (seg)
         SEG_0:     nib = 4'h0;
         SEG_1:     nib = 4'h1;
         SEG_2:     nib = 4'h2;
         SEG_3:     nib = 4'h3;
         SEG_4:     nib = 4'h4;
         SEG_5:     nib = 4'h5;
         SEG_6:     nib = 4'h6;
         SEG_7:     nib = 4'h7;
         SEG_8:     nib = 4'h8;
         SEG_9:     nib = 4'h9;
         SEG_A:     nib = 4'hA;
         SEG_B:     nib = 4'hB;
         SEG_C:     nib = 4'hC;
         SEG_D:     nib = 4'hD;
         SEG_E:     nib = 4'hE;
         SEG_F:     nib = 4'hF;
         SEG_BLANK: kind = KIND_BLANK;
         default:   kind = KIND_INV;
      endcase
   end

endmodule

// File: rtl/hex_seg_reader.sv
// Recovers the nibble shown on each digit of a multiplexed active-low
// 7-segment display, with a stability filter against scan glitches.
module hex_seg_reader
   import hex_seg_reader_pkg::*;
#(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   hex_seg_reader_if.master        bus,
   output logic [NIB_W*DIGITS-1:0] digit_val,
   output logic [DIGITS-1:0]       digit_ok,
   output logic                    ovf,
   input  logic                    clr_ovf
);

   localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned WORD_W = DIGITS + SEG_W;
   // Counter value on the last unchanged edge before entering CAPTURE;
   // the synchronizer compare looks one cycle ahead, hence the -2.
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 2);

   logic [WORD_W-1:0] sync1;
   logic [WORD_W-1:0] sync2;
   state_e            state;
   logic [CNT_W-1:0]  cnt;

   logic              changed_c;
   logic              capture_c;
   logic              onehot_c;
   logic              qualified_c;
   logic [DIGITS-1:0] an_low_c;
   logic [IDX_W-1:0]  idx_c;
   logic [NIB_W-1:0]  dec_nib;
   kind_e             dec_kind;

   // Two-flop synchronizer; resets to the inactive (all-ones) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= {bus.an, bus.seg};
         sync2 <= sync1;
      end
   end

   // The sample word w (sync2) is about to change on this edge.
   assign changed_c = (sync1 != sync2);
   assign capture_c = (state == ST_CAPTURE);

   // Stability FSM: settle on an unchanged word, capture once, hold until it moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_SETTLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_SETTLE: begin
               if (changed_c) begin
                  cnt <= '0;
               end else if (cnt == STABLE_LAST) begin
                  cnt   <= '0;
                  state <= ST_CAPTURE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_CAPTURE: begin
               cnt   <= '0;
               state <= changed_c ? ST_SETTLE : ST_HOLD;
            end
            ST_HOLD: begin
               if (changed_c) begin
                  cnt   <= '0;
                  state <= ST_SETTLE;
               end
            end
            default: begin
               cnt   <= '0;
               state <= ST_SETTLE;
            end
         endcase
      end
   end

   assign an_low_c = ~sync2[WORD_W-1:SEG_W];
   assign onehot_c = (an_low_c != '0) &&
                     ((an_low_c & (an_low_c - DIGITS'(1))) == '0);
   assign qualified_c = capture_c && onehot_c;

   // One-hot-low anode to digit index.
   always_comb begin
      idx_c = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (an_low_c[i]) idx_c = idx_c | IDX_W'(i);
      end
   end

   hex_seg_inv u_inv (
      .seg  (sync2[SEG_W-1:0]),
      .nib  (dec_nib),
      .kind (dec_kind)
   );

   // Per-digit registers updated on every qualified capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_val <= '0;
         digit_ok  <= '0;
      end else if (qualified_c) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (an_low_c[i]) begin
               if (dec_kind == KIND_HEX) begin
                  digit_val[NIB_W*i +: NIB_W] <= dec_nib;
                  digit_ok[i]                 <= 1'b1;
               end else begin
                  digit_ok[i] <= 1'b0;
               end
            end
         end
      end
   end

   // Single-entry event register; a capture against a stalled entry is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_idx   <= '0;
         bus.out_nib   <= '0;
         bus.out_kind  <= '0;
         ovf           <= 1'b0;
      end else begin
         if (clr_ovf) ovf <= 1'b0;
         if (qualified_c) begin
            if (bus.out_valid && !bus.out_ready) begin
               ovf <= 1'b1;
            end else begin
               bus.out_valid <= 1'b1;
               bus.out_idx   <= idx_c;
               bus.out_nib   <= dec_nib;
               bus.out_kind  <= dec_kind;
            end
         end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hex_seg_reader.sv
// Bench for hex_seg_reader: directed scenarios with literal expectations plus
// randomized display traffic checked every cycle against a run-length model.
module tb_hex_seg_reader;

   localparam int DIGITS = 4;
   localparam int STABLE = 4;

   localparam logic [6:0] HEX_TAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clr_ovf = 1'b0;
   logic [15:0] digit_val;
   logic [3:0]  digit_ok;
   logic        ovf;

   hex_seg_reader_if #(.DIGITS(DIGITS), .IDX_W(2)) bus ();

   hex_seg_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .digit_val (digit_val),
      .digit_ok  (digit_ok),
      .ovf       (ovf),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: a capture fires in the cycle the sampled word has been
   // the same for exactly STABLE cycles; w lags the pins by two edges.
   function automatic void decode(input logic [6:0] s, output logic [3:0] n, output logic [1:0] k);
      n = 4'h0;
      k = 2'd2;
      if (s == 7'h7F) k = 2'd1;
      for (int i = 0; i < 16; i++) begin
         if (s == HEX_TAB[i]) begin
            n = 4'(i);
            k = 2'd0;
         end
      end
   endfunction

   logic [10:0] m_s1, m_w;
   int          m_run;
   logic [15:0] m_dval;
   logic [3:0]  m_dok;
   logic        m_valid, m_ovf;
   logic [1:0]  m_idx, m_kind;
   logic [3:0]  m_nib;
   int          t_low, t_pos;
   logic [3:0]  t_nib;
   logic [1:0]  t_kind;
   logic        t_drop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = '1; m_w = '1; m_run = 1;
         m_dval = '0; m_dok = '0;
         m_valid = 1'b0; m_idx = '0; m_nib = '0; m_kind = '0; m_ovf = 1'b0;
      end else begin
         t_drop = 1'b0;
         t_low = 0;
         t_pos = 0;
         for (int i = 0; i < DIGITS; i++) begin
            if (!m_w[7+i]) begin
               t_low++;
               t_pos = i;
            end
         end
         if (m_run == STABLE && t_low == 1) begin
            decode(m_w[6:0], t_nib, t_kind);
            if (t_kind == 2'd0) begin
               m_dval[4*t_pos +: 4] = t_nib;
               m_dok[t_pos] = 1'b1;
            end else begin
               m_dok[t_pos] = 1'b0;
            end
            if (m_valid && !bus.out_ready) begin
               t_drop = 1'b1;
            end else begin
               m_valid = 1'b1;
               m_idx   = 2'(t_pos);
               m_nib   = t_nib;
               m_kind  = t_kind;
            end
         end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
         end
         if (t_drop) m_ovf = 1'b1;
         else if (clr_ovf) m_ovf = 1'b0;
         if (m_s1 == m_w) begin
            if (m_run < 1000) m_run++;
         end else begin
            m_run = 1;
         end
         m_w  = m_s1;
         m_s1 = {bus.an, bus.seg};
      end
   end

   int         xfer_cnt = 0;
   logic [1:0] last_idx = '0;
   logic [3:0] last_nib = '0;
   logic [1:0] last_kind = '0;

   // Per-cycle compare against the model, plus a log of accepted events.
   always @(negedge clk) begin
      if (chk_en) begin
         check("digit_val", 32'(digit_val), 32'(m_dval));
         check("digit_ok",  32'(digit_ok),  32'(m_dok));
         check("out_valid", 32'(bus.out_valid), 32'(m_valid));
         check("out_idx",   32'(bus.out_idx),   32'(m_idx));
         check("out_nib",   32'(bus.out_nib),   32'(m_nib));
         check("out_kind",  32'(bus.out_kind),  32'(m_kind));
         check("ovf",       32'(ovf),           32'(m_ovf));
         if (rst_n && bus.out_valid && bus.out_ready) begin
            xfer_cnt++;
            last_idx  = bus.out_idx;
            last_nib  = bus.out_nib;
            last_kind = bus.out_kind;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
      bus.an  = an;
      bus.seg = seg;
      repeat (n) step();
   endtask

   task automatic drive_rand(input logic [3:0] an, input logic [6:0] seg, input int n);
      bus.an  = an;
      bus.seg = seg;
      repeat (n) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         clr_ovf       = ($urandom_range(0, 15) == 0);
         step();
      end
      clr_ovf = 1'b0;
   endtask

   int snap;

   initial begin
      bus.an = 4'hF;
      bus.seg = 7'h7F;
      bus.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      step();
      step();
      check("rst_digit_val", 32'(digit_val), 32'h0);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_ovf", 32'(ovf), 32'h0);
      rst_n = 1'b1;
      drive(4'hF, 7'h7F, 8);

      // Hex capture: 2 on digit 0, visible exactly 6 edges after the drive.
      bus.an = 4'b1110;
      bus.seg = 7'b0100100;
      repeat (5) step();
      @(negedge clk);
      check("t1_early_valid", 32'(bus.out_valid), 32'h0);
      step();
      @(negedge clk);
      check("t1_valid", 32'(bus.out_valid), 32'h1);
      check("t1_idx", 32'(bus.out_idx), 32'h0);
      check("t1_nib", 32'(bus.out_nib), 32'h2);
      check("t1_kind", 32'(bus.out_kind), 32'h0);
      check("t1_dval0", 32'(digit_val[3:0]), 32'h2);
      check("t1_dok0", 32'(digit_ok[0]), 32'h1);
      step();
      @(negedge clk);
      check("t1_valid_drop", 32'(bus.out_valid), 32'h0);
      repeat (2) step();
      drive(4'hF, 7'h7F, 6);

      // Glitch rejection: short 5 then a held 8 on digit 1.
      snap = xfer_cnt;
      drive(4'b1101, 7'b0010010, 3);
      drive(4'b1101, 7'b0000000, 6);
      drive(4'hF, 7'h7F, 8);
      check("t2_events", 32'(xfer_cnt - snap), 32'h1);
      check("t2_idx", 32'(last_idx), 32'h1);
      check("t2_nib", 32'(last_nib), 32'h8);

      // Invalid then blank on digit 2 after a 7.
      drive(4'b1011, 7'b1111000, 8);
      check("t3_dval2", 32'(digit_val[11:8]), 32'h7);
      check("t3_dok2", 32'(digit_ok[2]), 32'h1);
      drive(4'b1011, 7'b0101010, 8);
      check("t3_inv_kind", 32'(last_kind), 32'h2);
      check("t3_inv_dok2", 32'(digit_ok[2]), 32'h0);
      check("t3_inv_dval2", 32'(digit_val[11:8]), 32'h7);
      drive(4'b1011, 7'b1111111, 8);
      check("t3_blank_kind", 32'(last_kind), 32'h1);
      drive(4'hF, 7'h7F, 4);

      // Bad enables: multiple-low and all-high produce nothing.
      snap = xfer_cnt;
      drive(4'b1100, 7'b0010010, 10);
      drive(4'b1111, 7'b0010010, 10);
      drive(4'hF, 7'h7F, 4);
      check("t4_events", 32'(xfer_cnt - snap), 32'h0);
      check("t4_dval", 32'(digit_val), 32'h0782);
      check("t4_dok", 32'(digit_ok), 32'h3);

      // Backpressure from a clean reset: second event dropped, ovf sticky.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      bus.out_ready = 1'b0;
      drive(4'hF, 7'h7F, 4);
      drive(4'b1110, 7'b0110000, 8);
      drive(4'b1101, 7'b0001000, 8);
      drive(4'hF, 7'h7F, 2);
      check("t5_valid", 32'(bus.out_valid), 32'h1);
      check("t5_idx", 32'(bus.out_idx), 32'h0);
      check("t5_nib", 32'(bus.out_nib), 32'h3);
      check("t5_ovf", 32'(ovf), 32'h1);
      check("t5_dval", 32'(digit_val), 32'h00A3);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check("t5_ovf_clr", 32'(ovf), 32'h0);
      snap = xfer_cnt;
      bus.out_ready = 1'b1;
      step();
      step();
      check("t5_events", 32'(xfer_cnt - snap), 32'h1);
      check("t5_valid_after", 32'(bus.out_valid), 32'h0);
      drive(4'hF, 7'h7F, 4);

      // Reset mid-settle, word kept: capture STABLE+2 edges after release.
      bus.an = 4'b0111;
      bus.seg = 7'b0000110;
      repeat (4) step();
      rst_n = 1'b0;
      repeat (2) step();
      @(negedge clk);
      check("t6_rst_dval", 32'(digit_val), 32'h0);
      check("t6_rst_valid", 32'(bus.out_valid), 32'h0);
      step();
      rst_n = 1'b1;
      repeat (5) step();
      @(negedge clk);
      check("t6_early_valid", 32'(bus.out_valid), 32'h0);
      step();
      @(negedge clk);
      check("t6_valid", 32'(bus.out_valid), 32'h1);
      check("t6_idx", 32'(bus.out_idx), 32'h3);
      check("t6_nib", 32'(bus.out_nib), 32'hE);
      drive(4'hF, 7'h7F, 4);

      // Random display traffic against the model.
      for (int it = 0; it < 400; it++) begin
         int sel;
         int hold;
         logic [3:0] an_v;
         logic [6:0] seg_v;
         sel  = $urandom_range(0, 19);
         hold = $urandom_range(1, 8);
         an_v = ~(4'b0001 << $urandom_range(0, 3));
         seg_v = HEX_TAB[$urandom_range(0, 15)];
         if (sel == 19) begin
            rst_n = 1'b0;
            repeat ($urandom_range(1, 2)) step();
            rst_n = 1'b1;
         end else begin
            if (sel >= 13 && sel < 15) seg_v = 7'h7F;
            else if (sel >= 15 && sel < 17) seg_v = 7'($urandom);
            else if (sel >= 17) begin
               case ($urandom_range(0, 3))
                  0: an_v = 4'hF;
                  1: an_v = 4'hC;
                  2: an_v = 4'h0;
                  default: an_v = 4'h5;
               endcase
            end
            drive_rand(an_v, seg_v, hold);
         end
      end

      bus.out_ready = 1'b1;
      drive(4'hF, 7'h7F, 10);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
